// File: rtl/ysyx_23060136_ifu_fetch_ctrl.sv
// IFU1 fetch sequencer: owns the fetch PC, issues one AXI4-Lite read at a time, redirects on trap/branch.
// Latency: 3 cycles minimum from REQ to inst_valid (REQ + WAIT + HOLD); one instruction per 3 cycles steady state.
// Backpressure: HOLD waits on FORWARD_stallIF; redirects during an in-flight read mark it stale and drop its data.
// Optional perf counters are enabled by defining YSYX_23060136_IFU_FETCH_PERF_EN.

`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 32
`endif
`ifndef ysyx_23060136_PC_RST
`define ysyx_23060136_PC_RST 32'h8000_0000
`endif

module ysyx_23060136_ifu_fetch_ctrl #(
    parameter int                BITS_W = `ysyx_23060136_BITS_W,
    parameter logic [BITS_W-1:0] PC_RST = `ysyx_23060136_PC_RST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              TRAP_valid,
    input  logic [BITS_W-1:0] TRAP_target,
    input  logic              BRANCH_PCSrc,
    input  logic [BITS_W-1:0] BRANCH_branch_target,
    input  logic              FORWARD_stallIF,
    output logic [BITS_W-1:0] IFU_araddr,
    output logic              IFU_arvalid,
    input  logic              IFU_arready,
    input  logic [31:0]       IFU_rdata,
    input  logic [1:0]        IFU_rresp,
    input  logic              IFU_rvalid,
    output logic              IFU_rready,
    output logic [BITS_W-1:0] IFU1_pc,
    output logic [31:0]       IFU_inst,
    output logic [BITS_W-1:0] IFU_inst_pc,
    output logic              IFU_inst_valid,
    output logic              IFU_access_fault
`ifdef YSYX_23060136_IFU_FETCH_PERF_EN
    ,
    output logic [63:0]       IFU_perf_fetch_cnt,
    output logic [31:0]       IFU_perf_kill_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [BITS_W-1:0] pc_q, pc_d;
    logic [BITS_W-1:0] addr_q, addr_d;
    logic              kill_q, kill_d;
    logic [31:0]       inst_q, inst_d;
    logic [BITS_W-1:0] inst_pc_q, inst_pc_d;
    logic              fault_q, fault_d;

    logic              redir;
    logic [BITS_W-1:0] redir_tgt;
    logic [BITS_W-1:0] pc_plus4;
    logic              consume;
    logic              drop;

    // Trap outranks branch; targets are used verbatim with no alignment check.
    assign redir     = TRAP_valid | BRANCH_PCSrc;
    assign redir_tgt = TRAP_valid ? TRAP_target : BRANCH_branch_target;
    assign pc_plus4  = pc_q + BITS_W'(4);

    // Handshake outputs decode registered state only, so no input-to-output path exists.
    assign IFU_arvalid      = (state_q == REQ);
    assign IFU_rready       = (state_q == WAIT);
    assign IFU_inst_valid   = (state_q == HOLD);
    assign IFU_araddr       = addr_q;
    assign IFU1_pc          = pc_q;
    assign IFU_inst         = inst_q;
    assign IFU_inst_pc      = inst_pc_q;
    assign IFU_access_fault = fault_q;

    // Next-state, PC/address and latched-instruction logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;
        consume   = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redir) begin
                    pc_d   = redir_tgt;
                    addr_d = redir_tgt;
                end else begin
                    addr_d = pc_q;
                end
            end
            REQ: begin
                // addr_q stays put until accepted; a redirect only retargets pc and marks the read stale.
                if (redir) begin
                    pc_d   = redir_tgt;
                    kill_d = 1'b1;
                end
                if (IFU_arready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (IFU_rvalid) begin
                    if (kill_q || redir) begin
                        // Stale response: discard and refetch from the newest PC.
                        drop    = 1'b1;
                        kill_d  = 1'b0;
                        pc_d    = redir ? redir_tgt : pc_q;
                        addr_d  = redir ? redir_tgt : pc_q;
                        state_d = REQ;
                    end else begin
                        inst_d    = (IFU_rresp != 2'b00) ? 32'h0 : IFU_rdata;
                        inst_pc_d = addr_q;
                        fault_d   = (IFU_rresp != 2'b00);
                        state_d   = HOLD;
                    end
                end else if (redir) begin
                    pc_d   = redir_tgt;
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d    = redir_tgt;
                    addr_d  = redir_tgt;
                    state_d = REQ;
                end else if (!FORWARD_stallIF) begin
                    consume = 1'b1;
                    pc_d    = pc_plus4;
                    addr_d  = pc_plus4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= PC_RST;
            addr_q    <= '0;
            kill_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

`ifdef YSYX_23060136_IFU_FETCH_PERF_EN
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    // Wrapping event counters: consumed instructions and discarded stale responses.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (consume ? 64'd1 : 64'd0);
        kill_cnt_d  = kill_cnt_q + (drop ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 64'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign IFU_perf_fetch_cnt = fetch_cnt_q;
    assign IFU_perf_kill_cnt  = kill_cnt_q;
`else
    logic unused_evt;
    assign unused_evt = consume ^ drop;
`endif

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch_ctrl.sv
// Directed bench for the IFU1 fetch sequencer with hand-computed expectations.
// Inputs are driven 1 time unit after each rising edge; outputs are checked at the same point.
// Default parameters: 32-bit PC, reset PC 0x80000000.

module tb_ysyx_23060136_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        TRAP_valid;
    logic [31:0] TRAP_target;
    logic        BRANCH_PCSrc;
    logic [31:0] BRANCH_branch_target;
    logic        FORWARD_stallIF;
    logic [31:0] IFU_araddr;
    logic        IFU_arvalid;
    logic        IFU_arready;
    logic [31:0] IFU_rdata;
    logic [1:0]  IFU_rresp;
    logic        IFU_rvalid;
    logic        IFU_rready;
    logic [31:0] IFU1_pc;
    logic [31:0] IFU_inst;
    logic [31:0] IFU_inst_pc;
    logic        IFU_inst_valid;
    logic        IFU_access_fault;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ysyx_23060136_ifu_fetch_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .TRAP_valid           (TRAP_valid),
        .TRAP_target          (TRAP_target),
        .BRANCH_PCSrc         (BRANCH_PCSrc),
        .BRANCH_branch_target (BRANCH_branch_target),
        .FORWARD_stallIF      (FORWARD_stallIF),
        .IFU_araddr           (IFU_araddr),
        .IFU_arvalid          (IFU_arvalid),
        .IFU_arready          (IFU_arready),
        .IFU_rdata            (IFU_rdata),
        .IFU_rresp            (IFU_rresp),
        .IFU_rvalid           (IFU_rvalid),
        .IFU_rready           (IFU_rready),
        .IFU1_pc              (IFU1_pc),
        .IFU_inst             (IFU_inst),
        .IFU_inst_pc          (IFU_inst_pc),
        .IFU_inst_valid       (IFU_inst_valid),
        .IFU_access_fault     (IFU_access_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        TRAP_valid = 1'b0;  TRAP_target = 32'h0;
        BRANCH_PCSrc = 1'b0; BRANCH_branch_target = 32'h0;
        FORWARD_stallIF = 1'b0;
        IFU_arready = 1'b0; IFU_rvalid = 1'b0;
        IFU_rdata = 32'h0;  IFU_rresp = 2'b00;
        step(); step();
        chk("rst_arvalid", {31'b0, IFU_arvalid}, 32'd0);
        chk("rst_rready", {31'b0, IFU_rready}, 32'd0);
        chk("rst_inst_valid", {31'b0, IFU_inst_valid}, 32'd0);
        chk("rst_pc", IFU1_pc, 32'h8000_0000);
        chk("rst_araddr", IFU_araddr, 32'h0);
        chk("rst_inst", IFU_inst, 32'h0);

        // Zero-wait memory fetch
        rst = 1'b0; IFU_arready = 1'b1; IFU_rvalid = 1'b1; IFU_rdata = 32'h1111_1111;
        step();
        chk("z_arvalid", {31'b0, IFU_arvalid}, 32'd1);
        chk("z_araddr", IFU_araddr, 32'h8000_0000);
        step();
        chk("z_rready", {31'b0, IFU_rready}, 32'd1);
        chk("z_arvalid_off", {31'b0, IFU_arvalid}, 32'd0);
        FORWARD_stallIF = 1'b1;
        step();
        chk("z_inst_valid", {31'b0, IFU_inst_valid}, 32'd1);
        chk("z_inst", IFU_inst, 32'h1111_1111);
        chk("z_inst_pc", IFU_inst_pc, 32'h8000_0000);
        chk("z_fault", {31'b0, IFU_access_fault}, 32'd0);

        // Stall for 5 cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'b0, IFU_inst_valid}, 32'd1);
            chk("stall_arvalid", {31'b0, IFU_arvalid}, 32'd0);
            chk("stall_inst", IFU_inst, 32'h1111_1111);
            chk("stall_inst_pc", IFU_inst_pc, 32'h8000_0000);
        end
        FORWARD_stallIF = 1'b0;
        step();
        chk("rel_arvalid", {31'b0, IFU_arvalid}, 32'd1);
        chk("rel_araddr", IFU_araddr, 32'h8000_0004);
        chk("rel_pc", IFU1_pc, 32'h8000_0004);

        // Branch while in WAIT, response 2 cycles later is dropped
        IFU_rvalid = 1'b0;
        step();
        chk("bw_rready", {31'b0, IFU_rready}, 32'd1);
        IFU_arready = 1'b0; BRANCH_PCSrc = 1'b1; BRANCH_branch_target = 32'h8000_0100;
        step();
        chk("bw_pc", IFU1_pc, 32'h8000_0100);
        chk("bw_still_wait", {31'b0, IFU_rready}, 32'd1);
        BRANCH_PCSrc = 1'b0;
        step();
        IFU_rvalid = 1'b1; IFU_rdata = 32'h2222_2222;
        step();
        chk("bw_no_inst", {31'b0, IFU_inst_valid}, 32'd0);
        chk("bw_arvalid", {31'b0, IFU_arvalid}, 32'd1);
        chk("bw_araddr", IFU_araddr, 32'h8000_0100);
        IFU_rvalid = 1'b0;

        // Simultaneous trap+branch in REQ with arready low
        TRAP_valid = 1'b1; TRAP_target = 32'h8000_1000;
        BRANCH_PCSrc = 1'b1; BRANCH_branch_target = 32'h8000_0200;
        step();
        chk("sim_araddr_hold", IFU_araddr, 32'h8000_0100);
        chk("sim_arvalid", {31'b0, IFU_arvalid}, 32'd1);
        chk("sim_pc", IFU1_pc, 32'h8000_1000);
        TRAP_valid = 1'b0; BRANCH_PCSrc = 1'b0;
        step();
        chk("sim_araddr_hold2", IFU_araddr, 32'h8000_0100);
        IFU_arready = 1'b1;
        step();
        chk("sim_wait", {31'b0, IFU_rready}, 32'd1);
        IFU_arready = 1'b0; IFU_rvalid = 1'b1; IFU_rdata = 32'h3333_3333;
        step();
        chk("sim_no_inst", {31'b0, IFU_inst_valid}, 32'd0);
        chk("sim_next_araddr", IFU_araddr, 32'h8000_1000);
        chk("sim_next_arvalid", {31'b0, IFU_arvalid}, 32'd1);

        // Error response
        IFU_rvalid = 1'b0; IFU_arready = 1'b1;
        step();
        IFU_arready = 1'b0; IFU_rvalid = 1'b1; IFU_rresp = 2'b10; IFU_rdata = 32'hDEAD_BEEF;
        FORWARD_stallIF = 1'b1;
        step();
        chk("err_valid", {31'b0, IFU_inst_valid}, 32'd1);
        chk("err_fault", {31'b0, IFU_access_fault}, 32'd1);
        chk("err_inst", IFU_inst, 32'h0);
        chk("err_inst_pc", IFU_inst_pc, 32'h8000_1000);

        // Redirect from HOLD to 0xFFFFFFFC (beats stall), then wrap on consume
        IFU_rvalid = 1'b0; IFU_rresp = 2'b00;
        BRANCH_PCSrc = 1'b1; BRANCH_branch_target = 32'hFFFF_FFFC;
        step();
        chk("wr_araddr", IFU_araddr, 32'hFFFF_FFFC);
        chk("wr_pc", IFU1_pc, 32'hFFFF_FFFC);
        chk("wr_arvalid", {31'b0, IFU_arvalid}, 32'd1);
        BRANCH_PCSrc = 1'b0; FORWARD_stallIF = 1'b0; IFU_arready = 1'b1;
        step();
        IFU_arready = 1'b0; IFU_rvalid = 1'b1; IFU_rdata = 32'h4444_4444;
        step();
        chk("wr_inst", IFU_inst, 32'h4444_4444);
        chk("wr_inst_pc", IFU_inst_pc, 32'hFFFF_FFFC);
        chk("wr_fault", {31'b0, IFU_access_fault}, 32'd0);
        IFU_rvalid = 1'b0;
        step();
        chk("wr_next_araddr", IFU_araddr, 32'h0000_0000);
        chk("wr_next_pc", IFU1_pc, 32'h0000_0000);

        // Reset in the middle of a request
        rst = 1'b1;
        step();
        chk("mrst_arvalid", {31'b0, IFU_arvalid}, 32'd0);
        chk("mrst_pc", IFU1_pc, 32'h8000_0000);
        chk("mrst_inst", IFU_inst, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
